// File: rtl/rr_lane_router_4.sv
// rr_lane_router_4: four-lane registered crossbar front end.
// A single-entry holding register per lane feeds one shared output stage through a
// round-robin arbiter; the winning word is presented on the lane with the same index.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     per-lane upstream handshake (ready = holding slot empty)
//   out_data/out_valid/out_ready  per-lane downstream handshake (only lane sel is live)
//   sel   index of the lane held in the output stage
//   busy  any holding register or the output stage occupied
module rr_lane_router_4 #(
  parameter int unsigned WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0][WIDTH-1:0] in_data,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ready,
  output logic [3:0][WIDTH-1:0] out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [1:0]            sel,
  output logic                  busy
);

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                    state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [LANES-1:0]          hold_full_q, hold_full_d;
  logic [SEL_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [LANES-1:0][WIDTH-1:0] out_data_d;
  logic [LANES-1:0]          out_valid_d;
  logic [SEL_W-1:0]          sel_d;
  logic [LANES-1:0]          in_ready_d;
  logic                      busy_d;

  logic [SEL_W-1:0]          grant;
  logic [SEL_W-1:0]          idx;
  logic                      found;
  logic                      drain;
  logic                      load;

  // Next-state: arbitration, output-stage load/drain and lane acceptance
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    sel_d       = sel;
    grant       = '0;
    idx         = '0;
    found       = 1'b0;

    // First occupied lane at or after rr_ptr, wrapping modulo 4
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = SEL_W'(rr_ptr_q + SEL_W'(k));
      if (!found && hold_full_q[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end

    // Only the lane currently presented can drain the stage
    drain = (state_q == S_FULL) && out_ready[sel];
    load  = ((state_q == S_EMPTY) || drain) && found;

    if (drain) begin
      state_d     = S_EMPTY;
      out_valid_d = '0;
      out_data_d  = '0;
    end

    if (load) begin
      state_d            = S_FULL;
      out_valid_d        = LANES'(1) << grant;
      out_data_d         = '0;
      out_data_d[grant]  = hold_q[grant];
      sel_d              = grant;
      hold_full_d[grant] = 1'b0;
      rr_ptr_d           = SEL_W'(grant + SEL_W'(1));
    end

    // A ready lane is empty, so it can never be the lane being transferred
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        hold_d[i]      = in_data[i];
        hold_full_d[i] = 1'b1;
      end
    end

    in_ready_d = ~hold_full_d;
    busy_d     = (|hold_full_d) | (|out_valid_d);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      hold_q      <= '0;
      hold_full_q <= '0;
      rr_ptr_q    <= '0;
      out_data    <= '0;
      out_valid   <= '0;
      sel         <= '0;
      in_ready    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      sel         <= sel_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_rr_lane_router_4.sv
// Bench for rr_lane_router_4: cycle vector table, hand-written corner sequences and a
// per-lane scoreboard over random traffic.
module tb_rr_lane_router_4;

  localparam int unsigned W = 2;

  logic             clock;
  logic             reset_n;
  logic [3:0][W-1:0] in_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][W-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       sel;
  logic             busy;

  int tests;
  int fails;

  rr_lane_router_4 #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] iv;
    logic [7:0] id;
    logic [3:0] ov;
    logic [1:0] sl;
    logic       chk_sel;
    logic [7:0] od;
    logic [3:0] ir;
    logic       bz;
  } vec_t;

  vec_t vecs[17];
  logic [1:0] sbq[4][$];

  function automatic vec_t mk(logic [3:0] iv, logic [7:0] id, logic [3:0] ov,
                              logic [1:0] sl, logic chk_sel, logic [7:0] od,
                              logic [3:0] ir, logic bz);
    vec_t v;
    v.iv = iv; v.id = id; v.ov = ov; v.sl = sl; v.chk_sel = chk_sel;
    v.od = od; v.ir = ir; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Retire a drained word against its lane queue, then log this cycle's acceptances
  task automatic sb_step();
    logic [1:0] exp;
    if (out_valid != 4'b0000) begin
      chk("sb_onehot", 8'(out_valid), 8'(4'b0001 << sel));
      if (out_ready[sel]) begin
        if (sbq[sel].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: lane %0d presented data %h with no word expected", sel, out_data[sel]);
        end else begin
          exp = sbq[sel].pop_front();
          chk("sb_data", 8'(out_data[sel]), 8'(exp));
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (in_valid[i] && in_ready[i]) sbq[i].push_back(in_data[i]);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    #1;
    chk("reset_in_ready", 8'(in_ready), 8'h00);
    chk("reset_out_valid", 8'(out_valid), 8'h00);

    // Fairness from rr_ptr=0, wrap check, single lane, back-to-back
    vecs[0]  = mk(4'b1111, 8'b11_10_01_00, 4'b0000, 2'd0, 1'b0, 8'h00,          4'b0000, 1'b1);
    vecs[1]  = mk(4'b0000, 8'h00,          4'b0001, 2'd0, 1'b1, 8'h00,          4'b0001, 1'b1);
    vecs[2]  = mk(4'b0000, 8'h00,          4'b0010, 2'd1, 1'b1, 8'b00_00_01_00, 4'b0011, 1'b1);
    vecs[3]  = mk(4'b0000, 8'h00,          4'b0100, 2'd2, 1'b1, 8'b00_10_00_00, 4'b0111, 1'b1);
    vecs[4]  = mk(4'b0000, 8'h00,          4'b1000, 2'd3, 1'b1, 8'b11_00_00_00, 4'b1111, 1'b1);
    vecs[5]  = mk(4'b0000, 8'h00,          4'b0000, 2'd0, 1'b0, 8'h00,          4'b1111, 1'b0);
    vecs[6]  = mk(4'b1001, 8'b01_00_00_10, 4'b0000, 2'd0, 1'b0, 8'h00,          4'b0110, 1'b1);
    vecs[7]  = mk(4'b0000, 8'h00,          4'b0001, 2'd0, 1'b1, 8'b00_00_00_10, 4'b0111, 1'b1);
    vecs[8]  = mk(4'b0000, 8'h00,          4'b1000, 2'd3, 1'b1, 8'b01_00_00_00, 4'b1111, 1'b1);
    vecs[9]  = mk(4'b0000, 8'h00,          4'b0000, 2'd0, 1'b0, 8'h00,          4'b1111, 1'b0);
    vecs[10] = mk(4'b0100, 8'b00_10_00_00, 4'b0000, 2'd0, 1'b0, 8'h00,          4'b1011, 1'b1);
    vecs[11] = mk(4'b0000, 8'h00,          4'b0100, 2'd2, 1'b1, 8'b00_10_00_00, 4'b1111, 1'b1);
    vecs[12] = mk(4'b0000, 8'h00,          4'b0000, 2'd0, 1'b0, 8'h00,          4'b1111, 1'b0);
    vecs[13] = mk(4'b0011, 8'b00_00_11_01, 4'b0000, 2'd0, 1'b0, 8'h00,          4'b1100, 1'b1);
    vecs[14] = mk(4'b0000, 8'h00,          4'b0001, 2'd0, 1'b1, 8'b00_00_00_01, 4'b1101, 1'b1);
    vecs[15] = mk(4'b0000, 8'h00,          4'b0010, 2'd1, 1'b1, 8'b00_00_11_00, 4'b1111, 1'b1);
    vecs[16] = mk(4'b0000, 8'h00,          4'b0000, 2'd0, 1'b0, 8'h00,          4'b1111, 1'b0);

    do_reset();
    chk("release_in_ready", 8'(in_ready), 8'h0F);
    chk("release_busy", 8'(busy), 8'h00);

    for (int v = 0; v < 17; v++) begin
      in_valid  = vecs[v].iv;
      in_data   = vecs[v].id;
      out_ready = 4'b1111;
      tick();
      chk($sformatf("vec%0d_out_valid", v), 8'(out_valid), 8'(vecs[v].ov));
      chk($sformatf("vec%0d_out_data", v), 8'(out_data), vecs[v].od);
      chk($sformatf("vec%0d_in_ready", v), 8'(in_ready), 8'(vecs[v].ir));
      chk($sformatf("vec%0d_busy", v), 8'(busy), 8'(vecs[v].bz));
      if (vecs[v].chk_sel) chk($sformatf("vec%0d_sel", v), 8'(sel), 8'(vecs[v].sl));
    end

    // Backpressure: lane 1 stalled in the output stage while lane 3 waits
    do_reset();
    in_valid  = 4'b1010;
    in_data   = 8'b11_00_10_00;
    out_ready = 4'b1101;
    tick();
    in_valid = '0;
    tick();
    chk("bp_load_valid", 8'(out_valid), 8'h02);
    chk("bp_load_sel", 8'(sel), 8'h01);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_stall_valid", 8'(out_valid), 8'h02);
      chk("bp_stall_data", 8'(out_data), 8'b00_00_10_00);
      chk("bp_stall_sel", 8'(sel), 8'h01);
      chk("bp_lane3_ready", 8'(in_ready[3]), 8'h00);
    end
    out_ready = 4'b1111;
    tick();
    chk("bp_next_valid", 8'(out_valid), 8'h08);
    chk("bp_next_sel", 8'(sel), 8'h03);
    chk("bp_next_data", 8'(out_data), 8'b11_00_00_00);
    tick();
    chk("bp_empty", 8'(out_valid), 8'h00);

    // Ready on lanes other than sel must not drain the stage
    do_reset();
    in_valid  = 4'b0001;
    in_data   = 8'b00_00_00_01;
    out_ready = 4'b1110;
    tick();
    in_valid = '0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("ign_valid", 8'(out_valid), 8'h01);
      chk("ign_data", 8'(out_data), 8'h01);
      tick();
    end
    out_ready = 4'b1111;
    tick();
    chk("ign_drained", 8'(out_valid), 8'h00);
    chk("ign_busy", 8'(busy), 8'h00);

    // Reset asserted mid-traffic clears everything immediately
    in_valid  = 4'b1111;
    in_data   = 8'b10_01_11_10;
    out_ready = 4'b1111;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(out_valid), 8'h00);
    chk("mid_rst_data", 8'(out_data), 8'h00);
    chk("mid_rst_sel", 8'(sel), 8'h00);
    chk("mid_rst_in_ready", 8'(in_ready), 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    in_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rel_in_ready", 8'(in_ready), 8'h0F);
    chk("mid_rel_valid", 8'(out_valid), 8'h00);
    chk("mid_rel_busy", 8'(busy), 8'h00);

    // Random traffic checked against per-lane queues
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      sb_step();
      tick();
    end
    in_valid  = '0;
    out_ready = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      sb_step();
      tick();
    end
    chk("sb_left_over", 8'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 8'h00);
    chk("sb_final_busy", 8'(busy), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
